// File: rtl/consmax_ctrl.sv
// Sequencer for one consmax datapath: loads both nibble LUTs from a host
// stream, then streams one row of elements and counts the returned results.
module consmax_ctrl #(
  parameter int IDATA_BIT = 8,
  parameter int CDATA_BIT = 8,
  parameter int LUT_DATA  = 16,
  parameter int LUT_ADDR  = IDATA_BIT >> 1,
  parameter int LUT_DEPTH = 2 ** LUT_ADDR,
  parameter int LEN_BIT   = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 cmd_load,
  input  logic                 cmd_run,
  input  logic [LEN_BIT-1:0]   cfg_row_len,
  input  logic [CDATA_BIT-1:0] cfg_shift,
  input  logic [LUT_DATA-1:0]  host_wdata,
  input  logic                 host_valid,
  output logic                 host_ready,
  input  logic [IDATA_BIT-1:0] s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [LUT_ADDR:0]    lut_waddr,
  output logic                 lut_wen,
  output logic [LUT_DATA-1:0]  lut_wdata,
  output logic [CDATA_BIT-1:0] cfg_consmax_shift,
  output logic [IDATA_BIT-1:0] idata,
  output logic                 idata_valid,
  input  logic                 odata_valid_in,
  output logic                 busy,
  output logic                 lut_loaded,
  output logic                 done,
  output logic                 err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  // 2*LUT_DEPTH: one past the last LUT1 entry
  localparam logic [LUT_ADDR+1:0] WADDR_END = {1'b1, {(LUT_ADDR+1){1'b0}}};
  localparam logic [LUT_ADDR+1:0] WADDR_ONE = {{(LUT_ADDR+1){1'b0}}, 1'b1};
  localparam logic [LEN_BIT-1:0]  LEN_ONE   = {{(LEN_BIT-1){1'b0}}, 1'b1};

  logic [1:0]           r_state;
  logic [LUT_ADDR+1:0]  r_waddr_cnt;
  logic [LEN_BIT-1:0]   r_row_len;
  logic [LEN_BIT-1:0]   r_issue_cnt;
  logic [LEN_BIT-1:0]   r_ret_cnt;
  logic                 r_lut_loaded;
  logic                 r_lut_wen;
  logic [LUT_ADDR:0]    r_lut_waddr;
  logic [LUT_DATA-1:0]  r_lut_wdata;
  logic [CDATA_BIT-1:0] r_shift;
  logic [IDATA_BIT-1:0] r_idata;
  logic                 r_idata_valid;
  logic                 r_done;
  logic                 r_err;

  logic                 w_host_ready;
  logic                 w_host_hs;
  logic                 w_s_ready;
  logic                 w_s_hs;
  logic                 w_ret_inc;
  logic [LEN_BIT-1:0]   w_ret_nxt;

  assign w_host_ready = (r_state == S_LOAD) && (r_waddr_cnt < WADDR_END);
  assign w_host_hs    = w_host_ready && host_valid;
  assign w_s_ready    = (r_state == S_RUN) && (r_issue_cnt < r_row_len);
  assign w_s_hs       = w_s_ready && s_valid;
  // Results saturate at row_len; stray valids beyond that are dropped.
  assign w_ret_inc    = odata_valid_in && ((r_state == S_RUN) || (r_state == S_DRAIN))
                        && (r_ret_cnt < r_row_len);
  assign w_ret_nxt    = w_ret_inc ? (r_ret_cnt + LEN_ONE) : r_ret_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= S_IDLE;
      r_waddr_cnt   <= '0;
      r_row_len     <= '0;
      r_issue_cnt   <= '0;
      r_ret_cnt     <= '0;
      r_lut_loaded  <= 1'b0;
      r_lut_wen     <= 1'b0;
      r_lut_waddr   <= '0;
      r_lut_wdata   <= '0;
      r_shift       <= '0;
      r_idata       <= '0;
      r_idata_valid <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_lut_wen     <= 1'b0;
      r_idata_valid <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      r_ret_cnt     <= w_ret_nxt;
      case (r_state)
        S_IDLE: begin
          // Load has priority; a simultaneous run is dropped silently.
          if (cmd_load) begin
            r_state      <= S_LOAD;
            r_waddr_cnt  <= '0;
            r_lut_loaded <= 1'b0;
          end else if (cmd_run) begin
            if (r_lut_loaded) begin
              r_row_len   <= cfg_row_len;
              r_shift     <= cfg_shift;
              r_issue_cnt <= '0;
              r_ret_cnt   <= '0;
              r_state     <= S_RUN;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (w_host_hs) begin
            r_lut_wen   <= 1'b1;
            r_lut_waddr <= r_waddr_cnt[LUT_ADDR:0];
            r_lut_wdata <= host_wdata;
            r_waddr_cnt <= r_waddr_cnt + WADDR_ONE;
          end else if (r_waddr_cnt == WADDR_END) begin
            r_state      <= S_IDLE;
            r_lut_loaded <= 1'b1;
          end
        end
        S_RUN: begin
          if (w_s_hs) begin
            r_idata       <= s_data;
            r_idata_valid <= 1'b1;
            r_issue_cnt   <= r_issue_cnt + LEN_ONE;
          end else if (r_issue_cnt == r_row_len) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // Look at the incoming result so done lands one cycle after the last one.
          if (w_ret_nxt == r_row_len) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign host_ready        = w_host_ready;
  assign s_ready           = w_s_ready;
  assign lut_waddr         = r_lut_waddr;
  assign lut_wen           = r_lut_wen;
  assign lut_wdata         = r_lut_wdata;
  assign cfg_consmax_shift = r_shift;
  assign idata             = r_idata;
  assign idata_valid       = r_idata_valid;
  assign busy              = (r_state != S_IDLE);
  assign lut_loaded        = r_lut_loaded;
  assign done              = r_done;
  assign err               = r_err;

endmodule

// File: tb/tb_consmax_ctrl.sv
// Bench for consmax_ctrl: random host/row traffic, queue scoreboard, 3-cycle datapath model.
module tb_consmax_ctrl;
  localparam int IDATA_BIT = 8;
  localparam int CDATA_BIT = 8;
  localparam int LUT_DATA  = 16;
  localparam int LUT_ADDR  = 4;
  localparam int LUT_DEPTH = 16;
  localparam int LEN_BIT   = 16;

  logic                 clk = 1'b0;
  logic                 rstn = 1'b0;
  logic                 cmd_load = 1'b0, cmd_run = 1'b0;
  logic [LEN_BIT-1:0]   cfg_row_len = '0;
  logic [CDATA_BIT-1:0] cfg_shift = '0;
  logic [LUT_DATA-1:0]  host_wdata = '0;
  logic                 host_valid = 1'b0, host_ready;
  logic [IDATA_BIT-1:0] s_data = '0;
  logic                 s_valid = 1'b0, s_ready;
  logic [LUT_ADDR:0]    lut_waddr;
  logic                 lut_wen;
  logic [LUT_DATA-1:0]  lut_wdata;
  logic [CDATA_BIT-1:0] cfg_consmax_shift;
  logic [IDATA_BIT-1:0] idata;
  logic                 idata_valid, odata_valid_in;
  logic                 busy, lut_loaded, done, err;

  always #5 clk = ~clk;

  consmax_ctrl dut (
    .clk(clk), .rstn(rstn), .cmd_load(cmd_load), .cmd_run(cmd_run),
    .cfg_row_len(cfg_row_len), .cfg_shift(cfg_shift),
    .host_wdata(host_wdata), .host_valid(host_valid), .host_ready(host_ready),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .lut_waddr(lut_waddr), .lut_wen(lut_wen), .lut_wdata(lut_wdata),
    .cfg_consmax_shift(cfg_consmax_shift), .idata(idata), .idata_valid(idata_valid),
    .odata_valid_in(odata_valid_in), .busy(busy), .lut_loaded(lut_loaded),
    .done(done), .err(err)
  );

  // Datapath stand-in: result valid 3 cycles after each input valid.
  logic [2:0] dl;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) dl <= '0;
    else       dl <= {dl[1:0], idata_valid};
  assign odata_valid_in = dl[2];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct packed { logic [LUT_ADDR:0] addr; logic [LUT_DATA-1:0] data; } lut_t;
  lut_t                 lut_q[$];
  logic [IDATA_BIT-1:0] data_q[$];
  logic [IDATA_BIT-1:0] fixed_q[$];
  int                   rows_q[$];
  logic [CDATA_BIT-1:0] exp_shift = '0;

  // Monitor: pops the scoreboard whenever the DUT presents a write, element or done.
  int   ret_seen = 0;
  bit   done_due = 0;
  lut_t me;
  logic [IDATA_BIT-1:0] md;
  always @(negedge clk) begin
    if (!rstn) begin
      ret_seen = 0;
      done_due = 0;
    end else begin
      if (lut_wen) begin
        if (lut_q.size() == 0) chk("lut_wen_unexpected", lut_wen, 0);
        else begin
          me = lut_q.pop_front();
          chk("lut_waddr", lut_waddr, me.addr);
          chk("lut_wdata", lut_wdata, me.data);
        end
      end
      if (idata_valid) begin
        if (data_q.size() == 0) chk("idata_unexpected", idata_valid, 0);
        else begin
          md = data_q.pop_front();
          chk("idata", idata, md);
          chk("shift_in_run", cfg_consmax_shift, exp_shift);
        end
      end
      if (done_due) begin
        chk("done_after_last_result", done, 1);
        if (rows_q.size() > 0) rows_q.delete(0);
        ret_seen = 0;
        done_due = 0;
      end else if (done) begin
        if (rows_q.size() > 0 && rows_q[0] == 0) begin
          chk("done_empty_row_results", ret_seen, 0);
          rows_q.delete(0);
        end else chk("done_unexpected", done, 0);
      end
      if (odata_valid_in) begin
        ret_seen++;
        if (rows_q.size() > 0 && ret_seen == rows_q[0]) done_due = 1;
      end
    end
  end

  // Tasks start and end at a negedge; inputs change only at negedges.
  task automatic do_load(input int n, input bit rnd_data, input bit with_run);
    int   k = 0, guard = 0;
    lut_t e;
    cmd_load = 1'b1; cmd_run = with_run;
    cfg_row_len = 16'd7; cfg_shift = ~exp_shift;
    @(negedge clk);
    cmd_load = 1'b0; cmd_run = 1'b0;
    chk("load_busy", busy, 1);
    chk("load_clears_loaded", lut_loaded, 0);
    chk("load_no_err", err, 0);
    chk("load_shift_kept", cfg_consmax_shift, exp_shift);
    while (k < n && guard < 2000) begin
      host_valid = ($urandom_range(0, 2) != 0);
      host_wdata = rnd_data ? 16'($urandom) : 16'h3F80 + 16'(k);
      if (host_valid && host_ready) begin
        e.addr = {(k >= LUT_DEPTH), 4'(k % LUT_DEPTH)};
        e.data = host_wdata;
        lut_q.push_back(e);
        k++;
      end
      @(negedge clk);
      guard++;
    end
    host_valid = 1'b0;
    if (guard >= 2000) chk("load_timeout", k, n);
    if (n == 2 * LUT_DEPTH) begin
      chk("host_ready_after_last", host_ready, 0);
      @(negedge clk);
      chk("lut_loaded_set", lut_loaded, 1);
      chk("load_returns_idle", busy, 0);
    end
  endtask

  task automatic run_row(input int len, input int gap_pct, input bit inject, input int shift);
    int i = 0, guard = 0;
    logic [CDATA_BIT-1:0] sh;
    sh = (shift < 0) ? 8'($urandom) : 8'(shift);
    cfg_row_len = 16'(len); cfg_shift = sh; cmd_run = 1'b1;
    @(negedge clk);
    cmd_run = 1'b0;
    rows_q.push_back(len);
    exp_shift = sh;
    chk("run_busy", busy, 1);
    chk("run_no_err", err, 0);
    chk("run_shift_latched", cfg_consmax_shift, sh);
    while (i < len && guard < 5000) begin
      s_valid = ($urandom_range(0, 99) >= gap_pct);
      s_data  = (fixed_q.size() > 0) ? fixed_q[0] : 8'($urandom);
      if (inject && i == 1) begin
        cmd_run = 1'b1; cmd_load = 1'b1; cfg_shift = ~sh; cfg_row_len = 16'd3;
      end else begin
        cmd_run = 1'b0; cmd_load = 1'b0;
      end
      if (s_valid && s_ready) begin
        data_q.push_back(s_data);
        if (fixed_q.size() > 0) fixed_q.delete(0);
        i++;
      end
      @(negedge clk);
      guard++;
    end
    s_valid = 1'b0; cmd_run = 1'b0; cmd_load = 1'b0;
    chk("issue_count", i, len);
    if (gap_pct == 0) chk("issue_back_to_back", guard, len);
    chk("s_ready_after_row", s_ready, 0);
    guard = 0;
    while (busy && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("row_finished", busy, 0);
    if (len == 0) chk("empty_row_latency", guard, 2);
    chk("shift_held", cfg_consmax_shift, sh);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_lut_wen", lut_wen, 0);
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_host_ready", host_ready, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_idata_valid", idata_valid, 0);
    chk("rst_outputs", {lut_waddr, lut_wdata, cfg_consmax_shift, idata}, '0);
    chk("rst_flags", {lut_loaded, done, err}, 0);

    // Run before any load
    cmd_run = 1'b1; cfg_row_len = 16'd4;
    @(negedge clk);
    cmd_run = 1'b0;
    chk("err_pulse", err, 1);
    chk("err_stays_idle", busy, 0);
    chk("err_s_ready", s_ready, 0);
    @(negedge clk);
    chk("err_single_cycle", err, 0);

    do_load(2 * LUT_DEPTH, 1'b0, 1'b0);

    fixed_q = '{8'h00, 8'h11, 8'h7F, 8'h80, 8'hFF};
    run_row(5, 0, 1'b0, 3);
    run_row(0, 20, 1'b0, -1);

    // Simultaneous load and run: load wins, no err, config untouched
    do_load(2 * LUT_DEPTH, 1'b1, 1'b1);

    for (int r = 0; r < 6; r++)
      run_row($urandom_range(2, 20), (r % 2) ? 35 : 0, (r == 2), -1);

    // Reset in the middle of a load
    do_load(10, 1'b1, 1'b0);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_loaded", lut_loaded, 0);
    chk("abort_outputs", {lut_wen, lut_waddr, lut_wdata, cfg_consmax_shift, idata, idata_valid}, '0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("abort_host_ready", host_ready, 0);
    cmd_run = 1'b1; cfg_row_len = 16'd2;
    @(negedge clk);
    cmd_run = 1'b0;
    chk("abort_run_err", err, 1);
    chk("abort_run_idle", busy, 0);
    repeat (4) @(negedge clk);

    chk("lut_queue_drained", lut_q.size(), 0);
    chk("data_queue_drained", data_q.size(), 0);
    chk("rows_queue_drained", rows_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
